// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 receive decoder.
//   state_t        decoder FSM states (SYNC, IDLE, HIGH)
//   WORD_W         bits per colour word
//   ADDR_W         width of the word index within a frame
//   MAX_WORDS      words per frame before overflow
//   DEF_*          default pulse timing in clk cycles
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam int unsigned WORD_W    = 24;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned MAX_WORDS = 64;

    localparam int unsigned DEF_T_THRESH   = 32;
    localparam int unsigned DEF_T_HIGH_MIN = 8;
    localparam int unsigned DEF_T_HIGH_MAX = 56;
    localparam int unsigned DEF_T_LATCH    = 2000;
    localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/ws2812_pulse_meas.sv
// ws2812_pulse_meas: synchronises the raw LED data line and measures pulse widths.
//   clk, reset      clock, asynchronous active-low reset
//   din_i           raw serial line (asynchronous to clk)
//   rise_o, fall_o  one-cycle edge strobes on the synchronised line
//   high_cnt_o      length of the current/just-ended high run, saturating
//   low_cnt_o       length of the current low run, saturating
//   fwd_en_i, dout_fwd_o   (WS2812_RX_FWD_EN only) gated, re-timed copy of the line
module ws2812_pulse_meas #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef WS2812_RX_FWD_EN
    input  logic             fwd_en_i,
    output logic             dout_fwd_o,
`endif
    input  logic             din_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] low_cnt_o
);

    logic             sync1_q;
    logic             ds_q;
    logic             ds_prev_q;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] low_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // On the falling-edge cycle high_cnt_q still holds the full high width,
    // because it was last updated while ds_q was high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            ds_q       <= 1'b0;
            ds_prev_q  <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
        end else begin
            sync1_q    <= din_i;
            ds_q       <= sync1_q;
            ds_prev_q  <= ds_q;
            high_cnt_q <= ds_q ? sat_inc(high_cnt_q) : '0;
            low_cnt_q  <= ds_q ? '0 : sat_inc(low_cnt_q);
        end
    end

    assign rise_o     = ds_q & ~ds_prev_q;
    assign fall_o     = ~ds_q & ds_prev_q;
    assign high_cnt_o = high_cnt_q;
    assign low_cnt_o  = low_cnt_q;

`ifdef WS2812_RX_FWD_EN
    logic dout_fwd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_fwd_q <= 1'b0;
        end else begin
            dout_fwd_q <= ds_q & fwd_en_i;
        end
    end

    assign dout_fwd_o = dout_fwd_q;
`endif

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire pulse-width decoder / loop-back monitor.
//   clk, reset   clock, asynchronous active-low reset
//   din          serial LED data line
//   en           decoder enable; low holds the FSM in SYNC with quiet outputs
//   word_valid   strobe: word_data / word_addr valid
//   word_data    24-bit word, first received bit in bit 23
//   word_addr    index of the word within the frame
//   frame_done   strobe on latch-gap detection
//   led_count    words in the last completed frame (0..64)
//   err          strobe on a malformed pulse or a partial word at latch
//   overflow     sticky, frame carried more than 64 words; cleared on frame_done
// Build option WS2812_RX_FWD_EN adds dout_fwd, the line re-timed by one clock
// and blanked until word 0 of the frame has been consumed.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned T_THRESH   = DEF_T_THRESH,
    parameter int unsigned T_HIGH_MIN = DEF_T_HIGH_MIN,
    parameter int unsigned T_HIGH_MAX = DEF_T_HIGH_MAX,
    parameter int unsigned T_LATCH    = DEF_T_LATCH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              en,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              frame_done,
    output logic [ADDR_W:0]   led_count,
    output logic              err,
`ifdef WS2812_RX_FWD_EN
    output logic              dout_fwd,
`endif
    output logic              overflow
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] HMIN_C   = CNT_W'(T_HIGH_MIN);
    localparam logic [CNT_W-1:0] HMAX_C   = CNT_W'(T_HIGH_MAX);
    localparam logic [CNT_W-1:0] LATCH_C  = CNT_W'(T_LATCH);
    localparam logic [ADDR_W:0]  MAXW_C   = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [4:0]       LAST_BIT = 5'(WORD_W - 1);

    logic             rise, fall;
    logic [CNT_W-1:0] high_cnt, low_cnt;

    state_t            state_q;
    logic [WORD_W-2:0] shreg_q;
    logic [4:0]        bit_cnt_q;
    logic [ADDR_W:0]   word_idx_q;
    logic              word_valid_q, frame_done_q, err_q, overflow_q;
    logic [WORD_W-1:0] word_data_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [ADDR_W:0]   led_count_q;

    logic              bit_d;
    logic [WORD_W-1:0] shreg_d;
    logic              latched;

    ws2812_pulse_meas #(.CNT_W(CNT_W)) u_meas (
        .clk        (clk),
        .reset      (reset),
`ifdef WS2812_RX_FWD_EN
        .fwd_en_i   ((state_q != SYNC) && (word_idx_q != '0)),
        .dout_fwd_o (dout_fwd),
`endif
        .din_i      (din),
        .rise_o     (rise),
        .fall_o     (fall),
        .high_cnt_o (high_cnt),
        .low_cnt_o  (low_cnt)
    );

    assign bit_d   = (high_cnt >= THRESH_C);
    assign shreg_d = {shreg_q, bit_d};
    assign latched = (low_cnt >= LATCH_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SYNC;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            word_idx_q   <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_addr_q  <= '0;
            frame_done_q <= 1'b0;
            led_count_q  <= '0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            if (!en) begin
                // Silent abort: frame progress dropped, no strobes.
                state_q    <= SYNC;
                bit_cnt_q  <= '0;
                word_idx_q <= '0;
            end else begin
                case (state_q)
                    SYNC: begin
                        // A full latch gap starts a fresh frame; anything left
                        // from an aborted frame is dropped without frame_done.
                        if (latched) begin
                            state_q    <= IDLE;
                            bit_cnt_q  <= '0;
                            word_idx_q <= '0;
                        end
                    end
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                        end else if (latched && (bit_cnt_q != '0 || word_idx_q != '0)) begin
                            frame_done_q <= 1'b1;
                            err_q        <= (bit_cnt_q != '0);
                            led_count_q  <= word_idx_q;
                            word_idx_q   <= '0;
                            bit_cnt_q    <= '0;
                            overflow_q   <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            if (high_cnt < HMIN_C || high_cnt > HMAX_C) begin
                                err_q     <= 1'b1;
                                state_q   <= SYNC;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                shreg_q <= shreg_d[WORD_W-2:0];
                                if (bit_cnt_q == LAST_BIT) begin
                                    bit_cnt_q <= '0;
                                    if (word_idx_q < MAXW_C) begin
                                        word_valid_q <= 1'b1;
                                        word_data_q  <= shreg_d;
                                        word_addr_q  <= word_idx_q[ADDR_W-1:0];
                                        word_idx_q   <= word_idx_q + 1'b1;
                                    end else begin
                                        overflow_q <= 1'b1;
                                    end
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                end
                            end
                        end else if (high_cnt > HMAX_C) begin
                            err_q     <= 1'b1;
                            state_q   <= SYNC;
                            bit_cnt_q <= '0;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_addr  = word_addr_q;
    assign frame_done = frame_done_q;
    assign led_count  = led_count_q;
    assign err        = err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: scoreboard bench for ws2812_rx. Expected words are queued as
// they are transmitted and checked by a monitor when word_valid strobes.
module tb_ws2812_rx;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic        en;
    logic        word_valid;
    logic [23:0] word_data;
    logic [5:0]  word_addr;
    logic        frame_done;
    logic [6:0]  led_count;
    logic        err;
    logic        overflow;
`ifdef WS2812_RX_FWD_EN
    logic        dout_fwd;
`endif

    always #(PERIOD / 2) clk = ~clk;

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_addr  (word_addr),
        .frame_done (frame_done),
        .led_count  (led_count),
        .err        (err),
`ifdef WS2812_RX_FWD_EN
        .dout_fwd   (dout_fwd),
`endif
        .overflow   (overflow)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [29:0] exp_q[$];
    int    wv_cnt = 0, fd_cnt = 0, err_cnt = 0, fd_err_cnt = 0;
    time   last_fall_t = 0;

    int t0h = 20, t0l = 43, t1h = 43, t1l = 20;

    // Monitor: sampled 2 time units after each rising edge.
    always begin
        logic [29:0] e;
        @(posedge clk);
        #2;
        if (word_valid === 1'b1) begin
            wv_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL word_unexpected got addr=%0d data=%06h required none", word_addr, word_data);
            end else begin
                e = exp_q.pop_front();
                if ({word_addr, word_data} !== e)
                    $display("FAIL word got addr=%0d data=%06h required addr=%0d data=%06h",
                             word_addr, word_data, e[29:24], e[23:0]);
                else
                    pass_cnt++;
            end
            // din falls at a negedge; three rising edges later word_valid is registered.
            total_cnt++;
            if (($time - last_fall_t) != 27)
                $display("FAIL word_latency got %0t required 27", $time - last_fall_t);
            else
                pass_cnt++;
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (err === 1'b1) err_cnt++;
        if (frame_done === 1'b1 && err === 1'b1) fd_err_cnt++;
    end

`ifdef WS2812_RX_FWD_EN
    logic [2:0] din_hist = 3'b000;
    bit fwd_chk = 0, fwd_gate = 0;
    int fwd_bad = 0, fwd_ones = 0;

    always begin
        logic exp_f;
        @(posedge clk);
        #2;
        if (fwd_chk) begin
            exp_f = fwd_gate ? din_hist[2] : 1'b0;
            if (dout_fwd !== exp_f) fwd_bad++;
            if (dout_fwd === 1'b1) fwd_ones++;
            if (word_valid === 1'b1) fwd_gate = 1;
        end
        din_hist = {din_hist[1:0], din};
    end
`endif

    task automatic idle_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        repeat (b ? t1h : t0h) @(negedge clk);
        din = 1'b0;
        last_fall_t = $time;
        repeat (b ? t1l : t0l) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] data, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(data[i]);
    endtask

    task automatic send_word(input logic [23:0] data, input bit expect_it, input logic [5:0] addr);
        if (expect_it) exp_q.push_back({addr, data});
        send_bits(data, 24);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        din = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (word_valid !== 1'b0) $display("FAIL rst_word_valid got %b required 0", word_valid); else pass_cnt++;
        total_cnt++; if (word_data !== 24'h0) $display("FAIL rst_word_data got %h required 0", word_data); else pass_cnt++;
        total_cnt++; if (word_addr !== 6'h0) $display("FAIL rst_word_addr got %h required 0", word_addr); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %b required 0", frame_done); else pass_cnt++;
        total_cnt++; if (led_count !== 7'h0) $display("FAIL rst_led_count got %0d required 0", led_count); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL rst_err got %b required 0", err); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b required 0", overflow); else pass_cnt++;
        din = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int wv0, fd0, er0;
        wv0 = wv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        idle_low(2010);
        send_word(24'h18FF00, 1, 6'd0);
        send_word(24'h000000, 1, 6'd1);
        send_word(24'hFFFFFF, 1, 6'd2);
        idle_low(3600);
        total_cnt++; if (wv_cnt - wv0 != 3) $display("FAIL basic_words got %0d required 3", wv_cnt - wv0); else pass_cnt++;
        total_cnt++; if (fd_cnt - fd0 != 1) $display("FAIL basic_frame_done got %0d required 1", fd_cnt - fd0); else pass_cnt++;
        total_cnt++; if (err_cnt - er0 != 0) $display("FAIL basic_err got %0d required 0", err_cnt - er0); else pass_cnt++;
        total_cnt++; if (led_count !== 7'd3) $display("FAIL basic_led_count got %0d required 3", led_count); else pass_cnt++;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL basic_pending got %0d required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_no_sync();
        int wv0, fd0;
        apply_reset();
        wv0 = wv_cnt; fd0 = fd_cnt;
        send_word(24'hA5A5A5, 0, 6'd0);
        send_word(24'h123456, 0, 6'd0);
        idle_low(3600);
        total_cnt++; if (wv_cnt - wv0 != 0) $display("FAIL nosync_words got %0d required 0", wv_cnt - wv0); else pass_cnt++;
        total_cnt++; if (fd_cnt - fd0 != 0) $display("FAIL nosync_frame_done got %0d required 0", fd_cnt - fd0); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int wv0, fd0, er0;
        wv0 = wv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        send_word(24'hC3C3C3, 1, 6'd0);
        send_bits(24'h5A5A5A, 10);
        din = 1'b1;
        repeat (5) @(negedge clk);
        din = 1'b0;
        repeat (43) @(negedge clk);
        total_cnt++; if (err_cnt - er0 != 1) $display("FAIL glitch_err got %0d required 1", err_cnt - er0); else pass_cnt++;
        send_bits(24'h5A5A5A, 14);
        total_cnt++; if (wv_cnt - wv0 != 1) $display("FAIL glitch_dropped_word got %0d required 1", wv_cnt - wv0); else pass_cnt++;
        idle_low(2100);
        send_word(24'h0F0F0F, 1, 6'd0);
        idle_low(3600);
        total_cnt++; if (fd_cnt - fd0 != 1) $display("FAIL glitch_frame_done got %0d required 1", fd_cnt - fd0); else pass_cnt++;
        total_cnt++; if (led_count !== 7'd1) $display("FAIL glitch_led_count got %0d required 1", led_count); else pass_cnt++;
    endtask

    task automatic test_partial();
        int fd0, er0, fe0;
        fd0 = fd_cnt; er0 = err_cnt; fe0 = fd_err_cnt;
        send_word(24'h800001, 1, 6'd0);
        send_bits(24'hFFFFFF, 10);
        idle_low(3600);
        total_cnt++; if (fd_cnt - fd0 != 1) $display("FAIL partial_frame_done got %0d required 1", fd_cnt - fd0); else pass_cnt++;
        total_cnt++; if (err_cnt - er0 != 1) $display("FAIL partial_err got %0d required 1", err_cnt - er0); else pass_cnt++;
        total_cnt++; if (fd_err_cnt - fe0 != 1) $display("FAIL partial_same_cycle got %0d required 1", fd_err_cnt - fe0); else pass_cnt++;
        total_cnt++; if (led_count !== 7'd1) $display("FAIL partial_led_count got %0d required 1", led_count); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int wv0, fd0;
        wv0 = wv_cnt; fd0 = fd_cnt;
        t0h = 10; t0l = 3; t1h = 40; t1l = 3;
        for (int i = 0; i < 66; i++)
            send_word(24'(i * 7 + 1), i < 64, 6'(i));
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b required 1", overflow); else pass_cnt++;
        idle_low(2100);
        t0h = 20; t0l = 43; t1h = 43; t1l = 20;
        total_cnt++; if (wv_cnt - wv0 != 64) $display("FAIL ovf_words got %0d required 64", wv_cnt - wv0); else pass_cnt++;
        total_cnt++; if (fd_cnt - fd0 != 1) $display("FAIL ovf_frame_done got %0d required 1", fd_cnt - fd0); else pass_cnt++;
        total_cnt++; if (led_count !== 7'd64) $display("FAIL ovf_led_count got %0d required 64", led_count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b required 0", overflow); else pass_cnt++;
    endtask

`ifdef WS2812_RX_FWD_EN
    task automatic test_fwd();
        fwd_gate = 0; fwd_bad = 0; fwd_ones = 0;
        fwd_chk = 1;
        send_word(24'hF0F0F0, 1, 6'd0);
        send_word(24'h3C5A96, 1, 6'd1);
        idle_low(2100);
        fwd_chk = 0;
        total_cnt++; if (fwd_bad != 0) $display("FAIL fwd_waveform got %0d bad cycles required 0", fwd_bad); else pass_cnt++;
        total_cnt++; if (fwd_ones == 0) $display("FAIL fwd_active got %0d high cycles required >0", fwd_ones); else pass_cnt++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        en    = 1'b1;
        test_reset();
        test_basic();
        test_no_sync();
        test_glitch();
        test_partial();
        test_overflow();
`ifdef WS2812_RX_FWD_EN
        test_fwd();
`endif
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
